// File: rtl/lcd_stream_decoder.sv
// lcd_stream_decoder
//   Consumer end of the tagged 17-bit video stream in the lcd-side FIFO.
//   It pops FIFO words, parses the framing tokens, and emits pixels with
//   x/y coordinates over a valid/ready handshake. On a framing violation it
//   reports the cause and resynchronises on the next frame start.
//
//   Optional feature: define LCD_STREAM_DECODER_STATS_EN to add the
//   frame_count / error_count statistics ports.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   queue_empty     FIFO empty flag
//   queue_data      FIFO output word (valid the cycle after queue_rd_en)
//   queue_rd_en     FIFO pop request (combinational)
//   pixel_ready     downstream accepts the head pixel this cycle
//   pixel_valid     pixel_data / pixel_x / pixel_y are valid
//   pixel_data      RGB565 pixel
//   pixel_x/y       pixel coordinates
//   frame_done      1-cycle pulse when a complete frame is closed
//   sync_error      1-cycle pulse on a framing violation
//   error_code      cause of the last violation (1 pixel/start, 2 early token, 3 illegal)
//   frame_count     (stats only) frames completed, wraps
//   error_count     (stats only) violations seen, wraps
module lcd_stream_decoder #(
  parameter int unsigned FRAME_WIDTH  = 480,
  parameter int unsigned FRAME_HEIGHT = 272
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        queue_empty,
  input  logic [16:0] queue_data,
  output logic        queue_rd_en,
  input  logic        pixel_ready,
  output logic        pixel_valid,
  output logic [15:0] pixel_data,
  output logic [15:0] pixel_x,
  output logic [15:0] pixel_y,
  output logic        frame_done,
  output logic        sync_error,
`ifdef LCD_STREAM_DECODER_STATS_EN
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
`endif
  output logic [1:0]  error_code
);

  localparam int unsigned CW = 16;
  localparam int unsigned QW = 17;

  localparam logic [QW-1:0] TOK_FRAME_START = 17'h10000;
  localparam logic [QW-1:0] TOK_ROW_START   = 17'h10001;
  localparam logic [QW-1:0] TOK_FRAME_END   = 17'h1FFFF;

  localparam logic [CW-1:0] X_LAST = CW'(FRAME_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_WAIT_ROW   = 2'd1,
    S_PIXELS     = 2'd2,
    S_WAIT_END   = 2'd3
  } state_t;

  typedef struct packed {
    logic [CW-1:0] data;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          inflight_q, inflight_d;
  pix_t          slot0_q, slot0_d;
  pix_t          slot1_q, slot1_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_error_q, sync_error_d;
  logic [1:0]    error_code_q, error_code_d;

  logic          push;
  logic          pop;
  pix_t          push_ent;
  logic          viol;
  logic [1:0]    viol_code;
  logic [1:0]    occ;

  logic is_fs, is_rs, is_fe, is_pix, is_ill;

  // Word classification of the sampled FIFO output.
  assign is_fs  = (queue_data == TOK_FRAME_START);
  assign is_rs  = (queue_data == TOK_ROW_START);
  assign is_fe  = (queue_data == TOK_FRAME_END);
  assign is_pix = ~queue_data[16];
  assign is_ill = queue_data[16] & ~is_fs & ~is_rs & ~is_fe;

  // Pop-aware occupancy: a slot freed this cycle can be reused by the word
  // requested now, which keeps one pixel per cycle under pixel_ready=1.
  assign pop         = vld0_q & pixel_ready;
  assign occ         = 2'(vld0_q) + 2'(vld1_q) - 2'(pop) + 2'(inflight_q);
  assign queue_rd_en = ~queue_empty & (occ < 2'd2);
  assign inflight_d  = queue_rd_en;

  // Token parser: next state, coordinates, pulses and pixel push.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    error_code_d = error_code_q;
    push         = 1'b0;
    push_ent     = {queue_data[CW-1:0], x_q, y_q};
    viol         = 1'b0;
    viol_code    = 2'd0;

    if (inflight_q) begin
      if (state_q == S_WAIT_FRAME) begin
        if (is_fs) begin
          state_d = S_WAIT_ROW;
          y_d     = '0;
        end
      end else if (is_ill) begin
        viol      = 1'b1;
        viol_code = 2'd3;
      end else if (is_fs) begin
        viol      = 1'b1;
        viol_code = 2'd1;
      end else begin
        unique case (state_q)
          S_WAIT_ROW: begin
            if (is_rs) begin
              state_d = S_PIXELS;
              x_d     = '0;
            end else begin
              // Frame end with rows still missing counts as an early token.
              viol      = 1'b1;
              viol_code = is_pix ? 2'd1 : 2'd2;
            end
          end
          S_PIXELS: begin
            if (is_pix) begin
              push = 1'b1;
              if (x_q == X_LAST) begin
                x_d     = '0;
                y_d     = y_q + 16'd1;
                state_d = (y_q == Y_LAST) ? S_WAIT_END : S_WAIT_ROW;
              end else begin
                x_d = x_q + 16'd1;
              end
            end else begin
              viol      = 1'b1;
              viol_code = 2'd2;
            end
          end
          S_WAIT_END: begin
            if (is_fe) begin
              frame_done_d = 1'b1;
              state_d      = S_WAIT_FRAME;
            end else begin
              viol      = 1'b1;
              viol_code = is_pix ? 2'd1 : 2'd2;
            end
          end
          default: state_d = S_WAIT_FRAME;
        endcase
      end

      if (viol) begin
        sync_error_d = 1'b1;
        error_code_d = viol_code;
        // A frame start is itself the resync point.
        if (is_fs) begin
          state_d = S_WAIT_ROW;
          y_d     = '0;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
    end
  end

  // Two-entry skid: slot0 is the head; pop shifts, push fills the first free slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    vld0_d  = vld0_q;
    vld1_d  = vld1_q;
    if (pop) begin
      slot0_d = slot1_q;
      vld0_d  = vld1_q;
      vld1_d  = 1'b0;
    end
    if (push) begin
      if (!vld0_d) begin
        slot0_d = push_ent;
        vld0_d  = 1'b1;
      end else begin
        slot1_d = push_ent;
        vld1_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_WAIT_FRAME;
      x_q          <= '0;
      y_q          <= '0;
      inflight_q   <= 1'b0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
      error_code_q <= 2'd0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      inflight_q   <= inflight_d;
      slot0_q      <= slot0_d;
      slot1_q      <= slot1_d;
      vld0_q       <= vld0_d;
      vld1_q       <= vld1_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
      error_code_q <= error_code_d;
    end
  end

`ifdef LCD_STREAM_DECODER_STATS_EN
  logic [CW-1:0] frame_count_q, frame_count_d;
  logic [CW-1:0] error_count_q, error_count_d;

  // Wrapping event counters, updated together with their pulses.
  always_comb begin
    frame_count_d = frame_count_q + CW'(frame_done_d);
    error_count_d = error_count_q + CW'(sync_error_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count_q <= '0;
      error_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign frame_count = frame_count_q;
  assign error_count = error_count_q;
`endif

  assign pixel_valid = vld0_q;
  assign pixel_data  = slot0_q.data;
  assign pixel_x     = slot0_q.x;
  assign pixel_y     = slot0_q.y;
  assign frame_done  = frame_done_q;
  assign sync_error  = sync_error_q;
  assign error_code  = error_code_q;

endmodule
